uart_tx_sched: RTL

Round-robin scheduler that shares one `uart_tx` byte transmitter between `N_REQ` independent requesters. It arbitrates pending byte requests and launches the winner with a single-cycle `start` pulse. It holds the byte stable for the whole frame, waits for the transmitter's `ok` pulse, and then reports completion to the owning requester. It sits between the FIFO/control logic and `uart_tx`; `uart_tx.rst_n` is driven from `~rst`.

---
 rtl/uart_tx_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Round-robin scheduler that shares one uart_tx byte transmitter between
//   N_REQ requesters. A winning request is latched and launched with a single
//   tx_start pulse. tx_data is then held for the whole frame. When uart_tx
//   reports ok, done is pulsed to the owner and an optional idle guard of GAP
//   cycles follows.
//
//   Optional feature macro: UART_TX_SCHED_TIMEOUT_EN
//     When defined, a frame that sees no tx_ok within TIMEOUT cycles is
//     aborted with an err pulse. When undefined, WAIT lasts until tx_ok or
//     reset, and err is tied low.
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   req       in   per-requester level request
//   req_data  in   byte of requester i at [8i+7:8i]
//   gnt       out  one-hot pulse, byte latched
//   done      out  one-hot pulse, frame finished
//   err       out  pulse, frame aborted by timeout
//   busy      out  high in every state except IDLE
//   tx_start  out  to uart_tx.start
//   tx_data   out  to uart_tx.data
//   tx_ok     in   from uart_tx.ok
//
// state  | meaning
// S_IDLE | arbitrate pending requests, launch the winner
// S_WAIT | frame in flight, tx_data held, waiting for tx_ok
// S_GAP  | idle-line guard, requests not sampled
module uart_tx_sched #(
    parameter int N_REQ   = 4,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               err,
    output logic               busy,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_ok
);

    localparam int LW = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

    state_t          r_state;
    logic [LW-1:0]   r_last;
    logic [3:0]      r_gap_cnt;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [7:0]      r_to_cnt;
`endif

    logic [LW-1:0]   w_cand;
    logic [LW-1:0]   w_win;
    logic            w_found;
    logic [N_REQ-1:0] w_win_oh;
    logic [N_REQ-1:0] w_last_oh;
    logic [7:0]      w_byte;

    // Circular search starting just after the last winner.
    always_comb begin
        w_win   = r_last;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = LW'((int'(r_last) + k) % N_REQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_win_oh  = N_REQ'(1) << w_win;
    assign w_last_oh = N_REQ'(1) << r_last;
    assign w_byte    = req_data[8*w_win +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_last    <= LW'(N_REQ - 1);
            r_gap_cnt <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            gnt      <= '0;
            done     <= '0;
            err      <= 1'b0;
            tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        tx_data  <= w_byte;
                        tx_start <= 1'b1;
                        gnt      <= w_win_oh;
                        r_last   <= w_win;
                        busy     <= 1'b1;
                        r_state  <= S_WAIT;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                        r_to_cnt <= 8'(TIMEOUT - 1);
`endif
                    end
                end
                S_WAIT: begin
                    // tx_ok takes priority over an expiring timeout.
                    if (tx_ok
`ifdef UART_TX_SCHED_TIMEOUT_EN
                        || r_to_cnt == 8'd0
`endif
                    ) begin
                        if (tx_ok)
                            done <= w_last_oh;
                        else
                            err <= 1'b1;
                        if (GAP > 0) begin
                            r_gap_cnt <= 4'(GAP - 1);
                            r_state   <= S_GAP;
                        end else begin
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    else begin
                        r_to_cnt <= r_to_cnt - 8'd1;
                    end
`endif
                end
                S_GAP: begin
                    if (r_gap_cnt == 4'd0) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
